// File: rtl/id_stage.sv
// id_stage: RV32I decode stage with operand forwarding, load-use detection and the ID/EX register
module id_stage (
  input  logic        dclk,
  input  logic        rst,
  input  logic        inst_valid_IF_i,
  input  logic [31:0] inst_IF_i,
  input  logic [31:0] pc_IF_i,
  output logic        stall_IF_o,
  output logic        re1_REG_o,
  output logic        re2_REG_o,
  output logic [4:0]  raddr1_REG_o,
  output logic [4:0]  raddr2_REG_o,
  input  logic [31:0] rdata1_REG_i,
  input  logic [31:0] rdata2_REG_i,
  input  logic        we_WB_i,
  input  logic [4:0]  waddr_WB_i,
  input  logic [31:0] wdata_WB_i,
  input  logic        we_EX_i,
  input  logic [4:0]  waddr_EX_i,
  input  logic [31:0] wdata_EX_i,
  input  logic        load_EX_i,
  input  logic        we_MEM_i,
  input  logic [4:0]  waddr_MEM_i,
  input  logic [31:0] wdata_MEM_i,
  input  logic        stall_EX_i,
  input  logic        flush_i,
  output logic        valid_EX_o,
  output logic [31:0] pc_EX_o,
  output logic [6:0]  opcode_EX_o,
  output logic [2:0]  funct3_EX_o,
  output logic        funct7b5_EX_o,
  output logic [31:0] opa_EX_o,
  output logic [31:0] opb_EX_o,
  output logic [31:0] imm_EX_o,
  output logic [31:0] rs2val_EX_o,
  output logic [4:0]  rd_EX_o,
  output logic        we_EX_o,
  output logic        illegal_EX_o
);
  localparam logic [6:0] op_lui = 7'h37, op_auipc = 7'h17, op_jal = 7'h6f, op_jalr = 7'h67,
                         op_br = 7'h63, op_ld = 7'h03, op_st = 7'h23, op_imm = 7'h13, op_op = 7'h33;
  function automatic logic uses_rs1(input logic [6:0] o);
    return o == op_jalr || o == op_br || o == op_ld || o == op_st || o == op_imm || o == op_op;
  endfunction
  function automatic logic uses_rs2(input logic [6:0] o);
    return o == op_br || o == op_st || o == op_op;
  endfunction
  logic        d_valid, hit1, hit2, use1, use2, known, loaduse, hold, adv, rd_we;
  logic [31:0] d_inst, d_pc, wb_q, imm, v1, v2, opa, opb;
  logic [6:0]  op;
  logic [4:0]  rs1, rs2, rd;
  always_comb begin
    op = d_inst[6:0];
    rs1 = d_inst[19:15];
    rs2 = d_inst[24:20];
    rd = d_inst[11:7];
    use1 = uses_rs1(op);
    use2 = uses_rs2(op);
    known = use1 || op == op_lui || op == op_auipc || op == op_jal;
    loaduse = d_valid && load_EX_i && we_EX_i && waddr_EX_i != 5'd0 &&
              ((use1 && waddr_EX_i == rs1) || (use2 && waddr_EX_i == rs2));
    hold = stall_EX_i || loaduse;
    adv = !hold || flush_i;
    stall_IF_o = hold && !flush_i && !rst;
    raddr1_REG_o = adv ? inst_IF_i[19:15] : rs1;
    raddr2_REG_o = adv ? inst_IF_i[24:20] : rs2;
    re1_REG_o = uses_rs1(adv ? inst_IF_i[6:0] : op);
    re2_REG_o = uses_rs2(adv ? inst_IF_i[6:0] : op);
    v1 = rs1 == 5'd0 ? 32'd0 :
         (we_EX_i && waddr_EX_i == rs1) ? wdata_EX_i :
         (we_MEM_i && waddr_MEM_i == rs1) ? wdata_MEM_i :
         hit1 ? wb_q : rdata1_REG_i;
    v2 = rs2 == 5'd0 ? 32'd0 :
         (we_EX_i && waddr_EX_i == rs2) ? wdata_EX_i :
         (we_MEM_i && waddr_MEM_i == rs2) ? wdata_MEM_i :
         hit2 ? wb_q : rdata2_REG_i;
    imm = (op == op_lui || op == op_auipc) ? {d_inst[31:12], 12'd0} :
          op == op_jal ? {{11{d_inst[31]}}, d_inst[31], d_inst[19:12], d_inst[20], d_inst[30:21], 1'b0} :
          op == op_br ? {{19{d_inst[31]}}, d_inst[31], d_inst[7], d_inst[30:25], d_inst[11:8], 1'b0} :
          op == op_st ? {{20{d_inst[31]}}, d_inst[31:25], d_inst[11:7]} :
          {{20{d_inst[31]}}, d_inst[31:20]};
    opa = (op == op_auipc || op == op_jal) ? d_pc : op == op_lui ? 32'd0 : v1;
    opb = (op == op_op || op == op_br) ? v2 : imm;
    rd_we = known && op != op_br && op != op_st && rd != 5'd0;
  end
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      d_valid <= 1'b0;
      d_inst <= '0;
      d_pc <= '0;
      hit1 <= 1'b0;
      hit2 <= 1'b0;
      wb_q <= '0;
      valid_EX_o <= 1'b0;
      pc_EX_o <= '0;
      opcode_EX_o <= '0;
      funct3_EX_o <= '0;
      funct7b5_EX_o <= 1'b0;
      opa_EX_o <= '0;
      opb_EX_o <= '0;
      imm_EX_o <= '0;
      rs2val_EX_o <= '0;
      rd_EX_o <= '0;
      we_EX_o <= 1'b0;
      illegal_EX_o <= 1'b0;
    end else begin
      hit1 <= we_WB_i && waddr_WB_i == raddr1_REG_o && raddr1_REG_o != 5'd0;
      hit2 <= we_WB_i && waddr_WB_i == raddr2_REG_o && raddr2_REG_o != 5'd0;
      wb_q <= wdata_WB_i;
      if (adv) begin
        d_valid <= inst_valid_IF_i && !flush_i;
        d_inst <= inst_IF_i;
        d_pc <= pc_IF_i;
      end
      if (flush_i || (!stall_EX_i && loaduse)) begin
        valid_EX_o <= 1'b0;
        we_EX_o <= 1'b0;
        illegal_EX_o <= 1'b0;
      end else if (!stall_EX_i) begin
        valid_EX_o <= d_valid;
        pc_EX_o <= d_pc;
        opcode_EX_o <= op;
        funct3_EX_o <= d_inst[14:12];
        funct7b5_EX_o <= d_inst[30];
        opa_EX_o <= opa;
        opb_EX_o <= opb;
        imm_EX_o <= imm;
        rs2val_EX_o <= v2;
        rd_EX_o <= rd;
        we_EX_o <= d_valid && rd_we;
        illegal_EX_o <= d_valid && !known;
      end
    end
  end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed self-checking bench for id_stage with a registered-read regfile model
module tb_id_stage;
  logic        dclk = 1'b0, rst = 1'b1;
  logic        inst_valid, stall_IF, re1, re2, we_WB, we_EX, load_EX, we_MEM, stall_EX, flush;
  logic [31:0] inst, pc, rdata1, rdata2, wdata_WB, wdata_EX, wdata_MEM;
  logic [4:0]  raddr1, raddr2, waddr_WB, waddr_EX, waddr_MEM, rd_EX;
  logic        valid_EX, f7b5_EX, we_EX_out, illegal_EX;
  logic [31:0] pc_EX, opa_EX, opb_EX, imm_EX, rs2val_EX;
  logic [6:0]  opcode_EX;
  logic [2:0]  f3_EX;
  logic [31:0] rf [32];
  int checks = 0, errors = 0;
  id_stage dut (
    .dclk(dclk), .rst(rst), .inst_valid_IF_i(inst_valid), .inst_IF_i(inst), .pc_IF_i(pc),
    .stall_IF_o(stall_IF), .re1_REG_o(re1), .re2_REG_o(re2), .raddr1_REG_o(raddr1), .raddr2_REG_o(raddr2),
    .rdata1_REG_i(rdata1), .rdata2_REG_i(rdata2), .we_WB_i(we_WB), .waddr_WB_i(waddr_WB), .wdata_WB_i(wdata_WB),
    .we_EX_i(we_EX), .waddr_EX_i(waddr_EX), .wdata_EX_i(wdata_EX), .load_EX_i(load_EX),
    .we_MEM_i(we_MEM), .waddr_MEM_i(waddr_MEM), .wdata_MEM_i(wdata_MEM), .stall_EX_i(stall_EX), .flush_i(flush),
    .valid_EX_o(valid_EX), .pc_EX_o(pc_EX), .opcode_EX_o(opcode_EX), .funct3_EX_o(f3_EX), .funct7b5_EX_o(f7b5_EX),
    .opa_EX_o(opa_EX), .opb_EX_o(opb_EX), .imm_EX_o(imm_EX), .rs2val_EX_o(rs2val_EX), .rd_EX_o(rd_EX),
    .we_EX_o(we_EX_out), .illegal_EX_o(illegal_EX)
  );
  always #5 dclk = ~dclk;
  always @(posedge dclk) begin
    if (rst)
      for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? 32'd0 : 32'h1000 + i;
    else if (we_WB && waddr_WB != 5'd0)
      rf[waddr_WB] <= wdata_WB;
    rdata1 <= rf[raddr1];
    rdata2 <= rf[raddr2];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %08h expected %08h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge dclk);
    #1;
  endtask
  task automatic feed(input logic v, input logic [31:0] i, input logic [31:0] p);
    inst_valid = v;
    inst = i;
    pc = p;
  endtask
  task automatic clear_side();
    we_WB = 0; waddr_WB = 0; wdata_WB = 0;
    we_EX = 0; waddr_EX = 0; wdata_EX = 0; load_EX = 0;
    we_MEM = 0; waddr_MEM = 0; wdata_MEM = 0;
    stall_EX = 0; flush = 0;
  endtask
  task automatic do_reset();
    clear_side();
    feed(0, 32'h0, 32'h0);
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    do_reset();
    check("rst_valid", valid_EX, 0);
    check("rst_stall", stall_IF, 0);
    check("rst_opa", opa_EX, 0);
    check("rst_imm", imm_EX, 0);
    check("rst_we", we_EX_out, 0);
    // addi x1,x0,5 then addi x2,x1,3: EX forward
    feed(1, 32'h00500093, 32'h0); tick();
    feed(1, 32'h00308113, 32'h4); #1;
    check("a2_raddr1", raddr1, 1);
    check("a2_re1", re1, 1);
    tick();
    check("a1_opa", opa_EX, 0);
    check("a1_imm", imm_EX, 5);
    check("a1_we", we_EX_out, 1);
    check("a1_rd", rd_EX, 1);
    feed(0, 32'h0, 32'h8);
    we_EX = 1; waddr_EX = 1; wdata_EX = 5; #1;
    check("a_stall", stall_IF, 0);
    tick();
    check("a2_valid", valid_EX, 1);
    check("a2_opa", opa_EX, 5);
    check("a2_imm", imm_EX, 3);
    check("a2_rd", rd_EX, 2);
    // lw x5,0(x1) then add x6,x5,x5: one bubble, then MEM forward
    do_reset();
    feed(1, 32'h0000A283, 32'h10); tick();
    feed(1, 32'h00528333, 32'h14); tick();
    check("lw_valid", valid_EX, 1);
    check("lw_opcode", opcode_EX, 7'h03);
    feed(1, 32'h00000013, 32'h18);
    we_EX = 1; waddr_EX = 5; wdata_EX = 32'hBAD0; load_EX = 1; #1;
    check("lu_stall", stall_IF, 1);
    check("lu_raddr1", raddr1, 5);
    tick();
    check("lu_bubble", valid_EX, 0);
    check("lu_bubble_we", we_EX_out, 0);
    we_EX = 0; load_EX = 0;
    we_MEM = 1; waddr_MEM = 5; wdata_MEM = 32'h1234; #1;
    check("lu_stall_rel", stall_IF, 0);
    tick();
    check("lu_add_valid", valid_EX, 1);
    check("lu_add_opa", opa_EX, 32'h1234);
    check("lu_add_opb", opb_EX, 32'h1234);
    check("lu_add_rd", rd_EX, 6);
    // sub x8,x7,x0 latched on the same edge WB writes x7
    do_reset();
    feed(1, 32'h40038433, 32'h20);
    we_WB = 1; waddr_WB = 7; wdata_WB = 32'hDEAD; tick();
    we_WB = 0;
    feed(0, 32'h0, 32'h24); tick();
    check("sb_opa", opa_EX, 32'hDEAD);
    check("sb_opb", opb_EX, 0);
    check("sb_f7b5", f7b5_EX, 1);
    check("sb_rd", rd_EX, 8);
    // stall_EX held for 3 cycles
    do_reset();
    feed(1, 32'h00500093, 32'h30); tick();
    feed(1, 32'h00700113, 32'h34); tick();
    feed(1, 32'h00900193, 32'h38);
    stall_EX = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("st_stall", stall_IF, 1);
      tick();
      check("st_imm", imm_EX, 5);
      check("st_pc", pc_EX, 32'h30);
    end
    stall_EX = 0; #1;
    check("st_rel_stall", stall_IF, 0);
    tick();
    check("st_i2_imm", imm_EX, 7);
    check("st_i2_pc", pc_EX, 32'h34);
    feed(0, 32'h0, 32'h3C); tick();
    check("st_i3_imm", imm_EX, 9);
    check("st_i3_valid", valid_EX, 1);
    // flush together with a load-use condition
    do_reset();
    feed(1, 32'h0000A283, 32'h40); tick();
    feed(1, 32'h00528333, 32'h44); tick();
    feed(1, 32'h00528333, 32'h48);
    we_EX = 1; waddr_EX = 5; load_EX = 1; flush = 1; #1;
    check("fl_stall", stall_IF, 0);
    tick();
    flush = 0; #1;
    check("fl_valid", valid_EX, 0);
    check("fl_dvalid_stall", stall_IF, 0);
    tick();
    check("fl_valid2", valid_EX, 0);
    check("fl_lu_again", stall_IF, 1);
    // immediate decode: jal, sw, illegal
    do_reset();
    feed(1, 32'hFFDFF0EF, 32'h100); tick();
    feed(1, 32'hFE21AC23, 32'h104); tick();
    check("jal_imm", imm_EX, 32'hFFFFFFFC);
    check("jal_opa", opa_EX, 32'h100);
    check("jal_we", we_EX_out, 1);
    check("jal_opcode", opcode_EX, 7'h6F);
    feed(1, 32'h0000007F, 32'h108); tick();
    check("sw_imm", imm_EX, 32'hFFFFFFF8);
    check("sw_we", we_EX_out, 0);
    check("sw_opa", opa_EX, 32'h1003);
    check("sw_rs2val", rs2val_EX, 32'h1002);
    check("sw_f3", f3_EX, 2);
    feed(0, 32'h0, 32'h10C); tick();
    check("ill_flag", illegal_EX, 1);
    check("ill_valid", valid_EX, 1);
    check("ill_we", we_EX_out, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
